hwpe_ctrl_job_sched: RTL and testbench

Job scheduler for the HWPE control slave. It manages `N_CONTEXT` register-file job contexts as a circular queue and arbitrates the ACQUIRE test-and-set between up to `N_CORES` offloading cores. It issues one start pulse per committed job to the engine, retires the job on the engine's done, and broadcasts completion events. It sits between the peripheral-bus register decode and the engine FSM, and drives the running and pointer context selects of the context-switched register file.

---
 rtl/hwpe_ctrl_job_sched.sv | 137 +++++++++++++
 tb/tb_hwpe_ctrl_job_sched.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_ctrl_job_sched.sv
// Job scheduler for the HWPE control slave: circular queue of register-file
// contexts, ACQUIRE/TRIGGER arbitration between cores, engine start/retire.
module hwpe_ctrl_job_sched #(
  parameter int N_CONTEXT = 2,
  parameter int N_CORES   = 16,
  parameter int N_EVT     = 2,
  parameter int ID_WIDTH  = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           clear_i,
  input  logic                           acquire_i,
  input  logic [$clog2(N_CORES)-1:0]     acquire_core_i,
  output logic [31:0]                    acquire_rdata_o,
  input  logic                           trigger_i,
  input  logic [$clog2(N_CORES)-1:0]     trigger_core_i,
  input  logic                           done_i,
  output logic                           start_o,
  output logic [$clog2(N_CONTEXT)-1:0]   running_ctx_o,
  output logic [$clog2(N_CONTEXT)-1:0]   pointer_ctx_o,
  output logic [ID_WIDTH-1:0]            running_id_o,
  output logic [$clog2(N_CONTEXT):0]     nb_queued_o,
  output logic                           busy_o,
  output logic                           locked_o,
  output logic                           finished_o,
  output logic [N_CORES*N_EVT-1:0]       evt_o
);

  localparam int CTX_W  = $clog2(N_CONTEXT);
  localparam int CORE_W = $clog2(N_CORES);
  localparam logic [CTX_W:0] MAX_COUNT = (CTX_W+1)'(N_CONTEXT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    RUNNING = 2'd2
  } state_e;

  state_e              state_r, state_nxt_s;
  logic                lock_r;
  logic [CORE_W-1:0]   lock_core_r;
  logic [ID_WIDTH-1:0] next_id_r;
  logic [ID_WIDTH-1:0] id_r [N_CONTEXT];
  logic [CTX_W:0]      count_r;
  logic [CTX_W-1:0]    ptr_r;
  logic [CTX_W-1:0]    run_r;
  logic                finished_r;

  logic can_acq_s, acq_fire_s, trig_fire_s, done_fire_s;

  // The ACQUIRE read value is live even without a strobe, so readers see what they would get.
  assign can_acq_s       = !lock_r && (count_r < MAX_COUNT);
  assign acq_fire_s      = acquire_i && can_acq_s;
  assign trig_fire_s     = trigger_i && lock_r && (trigger_core_i == lock_core_r);
  assign done_fire_s     = done_i && (state_r == RUNNING);
  assign acquire_rdata_o = can_acq_s ? {{(32-ID_WIDTH){1'b0}}, next_id_r} : 32'hFFFF_FFFF;

  assign start_o       = (state_r == START);
  assign running_ctx_o = run_r;
  assign pointer_ctx_o = ptr_r;
  assign running_id_o  = id_r[run_r];
  assign nb_queued_o   = count_r;
  assign busy_o        = (count_r != {(CTX_W+1){1'b0}});
  assign locked_o      = lock_r;
  assign finished_o    = finished_r;

  // Completion event fans out on line 0 of every core.
  always_comb begin
    evt_o = {(N_CORES*N_EVT){1'b0}};
    for (int c = 0; c < N_CORES; c++) begin
      evt_o[c*N_EVT] = finished_r;
    end
  end

  // Engine FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Engine FSM next-state; soft clear aborts any job in flight.
  always_comb begin
    state_nxt_s = state_r;
    if (clear_i) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = (count_r != {(CTX_W+1){1'b0}}) ? START : IDLE;
        START:   state_nxt_s = RUNNING;
        RUNNING: state_nxt_s = done_i ? IDLE : RUNNING;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Queue bookkeeping: lock ownership, IDs, pointers and occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_r      <= 1'b0;
      lock_core_r <= {CORE_W{1'b0}};
      next_id_r   <= {ID_WIDTH{1'b0}};
      count_r     <= {(CTX_W+1){1'b0}};
      ptr_r       <= {CTX_W{1'b0}};
      run_r       <= {CTX_W{1'b0}};
      finished_r  <= 1'b0;
      for (int i = 0; i < N_CONTEXT; i++) id_r[i] <= {ID_WIDTH{1'b0}};
    end else if (clear_i) begin
      lock_r      <= 1'b0;
      lock_core_r <= {CORE_W{1'b0}};
      next_id_r   <= {ID_WIDTH{1'b0}};
      count_r     <= {(CTX_W+1){1'b0}};
      ptr_r       <= {CTX_W{1'b0}};
      run_r       <= {CTX_W{1'b0}};
      finished_r  <= 1'b0;
      for (int i = 0; i < N_CONTEXT; i++) id_r[i] <= {ID_WIDTH{1'b0}};
    end else begin
      finished_r <= done_fire_s;
      if (acq_fire_s) begin
        lock_r      <= 1'b1;
        lock_core_r <= acquire_core_i;
        id_r[ptr_r] <= next_id_r;
        next_id_r   <= next_id_r + {{(ID_WIDTH-1){1'b0}}, 1'b1};
      end else if (trig_fire_s) begin
        lock_r <= 1'b0;
        ptr_r  <= ptr_r + {{(CTX_W-1){1'b0}}, 1'b1};
      end
      if (done_fire_s) begin
        run_r <= run_r + {{(CTX_W-1){1'b0}}, 1'b1};
      end
      count_r <= count_r + {{CTX_W{1'b0}}, trig_fire_s} - {{CTX_W{1'b0}}, done_fire_s};
    end
  end

endmodule

// File: tb/tb_hwpe_ctrl_job_sched.sv
// Directed self-checking bench for hwpe_ctrl_job_sched (N_CONTEXT=2, N_CORES=16, N_EVT=2, ID_WIDTH=8).
module tb_hwpe_ctrl_job_sched;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        clear_i = 1'b0;
  logic        acquire_i = 1'b0;
  logic [3:0]  acquire_core_i = 4'd0;
  logic [31:0] acquire_rdata_o;
  logic        trigger_i = 1'b0;
  logic [3:0]  trigger_core_i = 4'd0;
  logic        done_i = 1'b0;
  logic        start_o;
  logic [0:0]  running_ctx_o;
  logic [0:0]  pointer_ctx_o;
  logic [7:0]  running_id_o;
  logic [1:0]  nb_queued_o;
  logic        busy_o;
  logic        locked_o;
  logic        finished_o;
  logic [31:0] evt_o;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  hwpe_ctrl_job_sched #(
    .N_CONTEXT(2), .N_CORES(16), .N_EVT(2), .ID_WIDTH(8)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i),
    .acquire_i(acquire_i), .acquire_core_i(acquire_core_i), .acquire_rdata_o(acquire_rdata_o),
    .trigger_i(trigger_i), .trigger_core_i(trigger_core_i), .done_i(done_i),
    .start_o(start_o), .running_ctx_o(running_ctx_o), .pointer_ctx_o(pointer_ctx_o),
    .running_id_o(running_id_o), .nb_queued_o(nb_queued_o), .busy_o(busy_o),
    .locked_o(locked_o), .finished_o(finished_o), .evt_o(evt_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; clear_i = 1'b0; acquire_i = 1'b0; trigger_i = 1'b0; done_i = 1'b0;
    acquire_core_i = 4'd0; trigger_core_i = 4'd0;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic do_acq(input logic [3:0] core, output logic [31:0] rd);
    acquire_i = 1'b1; acquire_core_i = core;
    #1;
    rd = acquire_rdata_o;
    tick();
    acquire_i = 1'b0;
  endtask

  task automatic do_trig(input logic [3:0] core);
    trigger_i = 1'b1; trigger_core_i = core;
    tick();
    trigger_i = 1'b0;
  endtask

  task automatic do_done();
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
  endtask

  task automatic wait_start(output bit seen);
    int k;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 8) begin
      if (start_o) seen = 1'b1;
      else begin
        tick();
        k++;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    do_reset();
    total++;
    if ({start_o, running_ctx_o, pointer_ctx_o, running_id_o, nb_queued_o, busy_o,
         locked_o, finished_o, evt_o, acquire_rdata_o} !== 81'd0)
      $display("FAIL reset_outputs: got start=%b rctx=%0d pctx=%0d id=%0d nq=%0d busy=%b lock=%b fin=%b evt=%h rd=%h, want all 0",
               start_o, running_ctx_o, pointer_ctx_o, running_id_o, nb_queued_o, busy_o,
               locked_o, finished_o, evt_o, acquire_rdata_o);
    else passed++;
    do_acq(4'd3, rd);
    total++; if (rd !== 32'd0) $display("FAIL first_acquire: got %h want 0", rd); else passed++;
    total++; if (locked_o !== 1'b1) $display("FAIL locked_after_acq: got %b want 1", locked_o); else passed++;
    do_trig(4'd3);
    total++; if (start_o !== 1'b0 || nb_queued_o !== 2'd1 || busy_o !== 1'b1)
      $display("FAIL trig_t1: got start=%b nq=%0d busy=%b want 0/1/1", start_o, nb_queued_o, busy_o);
    else passed++;
    tick();
    total++; if (start_o !== 1'b1 || running_ctx_o !== 1'b0 || running_id_o !== 8'd0)
      $display("FAIL start_t2: got start=%b rctx=%0d id=%0d want 1/0/0", start_o, running_ctx_o, running_id_o);
    else passed++;
    tick();
    total++; if (start_o !== 1'b0) $display("FAIL start_one_cycle: got %b want 0", start_o); else passed++;
  endtask

  task automatic test_full_queue();
    logic [31:0] rd;
    do_reset();
    do_acq(4'd0, rd);
    do_trig(4'd0);
    do_acq(4'd0, rd);
    total++; if (rd !== 32'd1) $display("FAIL second_id: got %h want 1", rd); else passed++;
    do_trig(4'd0);
    total++; if (nb_queued_o !== 2'd2) $display("FAIL two_queued: got %0d want 2", nb_queued_o); else passed++;
    do_acq(4'd0, rd);
    total++; if (rd !== 32'hFFFF_FFFF || locked_o !== 1'b0)
      $display("FAIL full_acquire: got rd=%h lock=%b want ffffffff/0", rd, locked_o);
    else passed++;
    do_done();
    total++; if (finished_o !== 1'b1 || evt_o !== 32'h5555_5555 || nb_queued_o !== 2'd1)
      $display("FAIL retire_events: got fin=%b evt=%h nq=%0d want 1/55555555/1", finished_o, evt_o, nb_queued_o);
    else passed++;
    total++; if (pointer_ctx_o !== 1'b0) $display("FAIL pointer_wrap: got %0d want 0", pointer_ctx_o); else passed++;
    do_acq(4'd5, rd);
    total++; if (rd !== 32'd2) $display("FAIL acquire_after_retire: got %h want 2", rd); else passed++;
    total++; if (finished_o !== 1'b0 || evt_o !== 32'd0)
      $display("FAIL event_one_cycle: got fin=%b evt=%h want 0/0", finished_o, evt_o);
    else passed++;
    total++; if (start_o !== 1'b1 || running_ctx_o !== 1'b1 || running_id_o !== 8'd1)
      $display("FAIL second_start: got start=%b rctx=%0d id=%0d want 1/1/1", start_o, running_ctx_o, running_id_o);
    else passed++;
  endtask

  task automatic test_lock_owner();
    logic [31:0] rd;
    do_reset();
    do_acq(4'd1, rd);
    do_acq(4'd2, rd);
    total++; if (rd !== 32'hFFFF_FFFF) $display("FAIL foreign_acquire: got %h want ffffffff", rd); else passed++;
    do_trig(4'd2);
    total++; if (nb_queued_o !== 2'd0 || locked_o !== 1'b1)
      $display("FAIL foreign_trigger: got nq=%0d lock=%b want 0/1", nb_queued_o, locked_o);
    else passed++;
    do_trig(4'd1);
    total++; if (nb_queued_o !== 2'd1 || locked_o !== 1'b0 || pointer_ctx_o !== 1'b1)
      $display("FAIL owner_trigger: got nq=%0d lock=%b pctx=%0d want 1/0/1", nb_queued_o, locked_o, pointer_ctx_o);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    do_reset();
    do_acq(4'd0, rd);
    do_trig(4'd0);
    do_acq(4'd0, rd);
    total++; if (start_o !== 1'b1) $display("FAIL b2b_first_start: got %b want 1", start_o); else passed++;
    tick();
    trigger_i = 1'b1; trigger_core_i = 4'd0; done_i = 1'b1;
    tick();
    trigger_i = 1'b0; done_i = 1'b0;
    total++; if (nb_queued_o !== 2'd1 || finished_o !== 1'b1 || start_o !== 1'b0)
      $display("FAIL trig_done_same: got nq=%0d fin=%b start=%b want 1/1/0", nb_queued_o, finished_o, start_o);
    else passed++;
    tick();
    total++; if (start_o !== 1'b1 || running_ctx_o !== 1'b1 || running_id_o !== 8'd1)
      $display("FAIL b2b_next_start: got start=%b rctx=%0d id=%0d want 1/1/1", start_o, running_ctx_o, running_id_o);
    else passed++;
  endtask

  task automatic test_id_wrap();
    logic [31:0] rd;
    bit seen;
    int bad;
    bad = 0;
    do_reset();
    for (int i = 0; i < 257; i++) begin
      do_acq(4'(i % 16), rd);
      total++; if (rd !== 32'(i % 256)) begin $display("FAIL wrap_acq_id: round %0d got %h want %h", i, rd, i % 256); bad++; end else passed++;
      do_trig(4'(i % 16));
      wait_start(seen);
      total++;
      if (!seen) begin $display("FAIL wrap_start_timeout: round %0d got no start want start", i); bad++; end
      else if (running_id_o !== 8'(i % 256) || running_ctx_o !== 1'(i % 2))
        begin $display("FAIL wrap_running: round %0d got id=%0d ctx=%0d want %0d/%0d", i, running_id_o, running_ctx_o, i % 256, i % 2); bad++; end
      else passed++;
      tick();
      do_done();
      total++; if (pointer_ctx_o !== 1'((i + 1) % 2) || running_ctx_o !== 1'((i + 1) % 2) || nb_queued_o !== 2'd0)
        begin $display("FAIL wrap_pointers: round %0d got p=%0d r=%0d nq=%0d", i, pointer_ctx_o, running_ctx_o, nb_queued_o); bad++; end
      else passed++;
      if (bad > 5) break;
    end
    total++; if (acquire_rdata_o !== 32'd1) $display("FAIL wrap_next_id: got %h want 1", acquire_rdata_o); else passed++;
  endtask

  task automatic test_clear();
    logic [31:0] rd;
    bit seen;
    do_reset();
    do_acq(4'd4, rd);
    do_trig(4'd4);
    do_acq(4'd4, rd);
    wait_start(seen);
    tick();
    total++; if (!seen || locked_o !== 1'b1 || busy_o !== 1'b1)
      $display("FAIL clear_setup: got seen=%b lock=%b busy=%b want 1/1/1", seen, locked_o, busy_o);
    else passed++;
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    total++;
    if ({start_o, running_ctx_o, pointer_ctx_o, running_id_o, nb_queued_o, busy_o,
         locked_o, finished_o, evt_o, acquire_rdata_o} !== 81'd0)
      $display("FAIL clear_outputs: got start=%b pctx=%0d id=%0d nq=%0d lock=%b fin=%b evt=%h rd=%h, want all 0",
               start_o, pointer_ctx_o, running_id_o, nb_queued_o, locked_o, finished_o, evt_o, acquire_rdata_o);
    else passed++;
    do_done();
    total++; if (finished_o !== 1'b0 || evt_o !== 32'd0 || nb_queued_o !== 2'd0 || running_ctx_o !== 1'b0)
      $display("FAIL done_after_clear: got fin=%b evt=%h nq=%0d rctx=%0d want 0/0/0/0", finished_o, evt_o, nb_queued_o, running_ctx_o);
    else passed++;
    tick();
    total++; if (start_o !== 1'b0 || finished_o !== 1'b0)
      $display("FAIL idle_after_clear: got start=%b fin=%b want 0/0", start_o, finished_o);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_full_queue();
    test_lock_owner();
    test_back_to_back();
    test_id_wrap();
    test_clear();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
